ni_csr_irq_ctrl: RTL and testbench
==================================

Name: ni_csr_irq_ctrl

Overview:
Second-generation network-interface CSR bank with per-VC interrupt control, for each router's NI AXI slave.
- Decodes single-beat CSR read/write requests from the AXI slave front end.
- Generalises channel count and data widths.
- Adds sticky write-1-to-clear pending flags, a per-VC mask, a selectable trigger mode with a programmable occupancy threshold, and an interrupt-coalescing timer.
- Responses are registered, 1-cycle latency.

Parameters:
NUM_VC, 3, number of virtual channels (1..16)
ROUTER_X_ID, 0, router row id reported at X_ID
ROUTER_Y_ID, 0, router column id reported at Y_ID
ADDR_W, 16, CSR offset width (byte address, word aligned)
OCUP_W, 16, FIFO occupancy width per VC
PKT_W, 8, packet-size field width per VC
COAL_W, 16, coalescing counter/timeout width
VERSION, 32'h0002_0000, value returned at VERSION

Ports:
clk_axi  in  1  AXI clock
arst_axi_n  in  1  async active-low reset
csr_valid_i  in  1  request valid
csr_wr_i  in  1  1=write, 0=read
csr_addr_i  in  ADDR_W  offset from CSR base
csr_wdata_i  in  32  write data
csr_ready_o  out  1  request accept, tied 1
csr_rvalid_o  out  1  response valid, 1 cycle after request
csr_rdata_o  out  32  read data (held until next read)
csr_error_o  out  1  response error, qualified by csr_rvalid_o
empty_vc_i  in  NUM_VC  rd-buffer empty per VC
full_vc_i  in  NUM_VC  rd-buffer full per VC
ocup_vc_i  in  NUM_VC*OCUP_W  rd-buffer occupancy per VC
pkt_size_vc_i  in  NUM_VC*PKT_W  head packet size per VC
irq_vcs_o  out  NUM_VC  pending & mask per VC
irq_trig_o  out  1  coalesced interrupt line

Behaviour:
- Interface: one clock, clk_axi; reset arst_axi_n is asynchronous, active-low. All flops reset on assertion; release is synchronous to clk_axi.
- Reset values:
  - Outputs: csr_rvalid_o=0, csr_rdata_o=0, csr_error_o=0, irq_vcs_o=0, irq_trig_o=0.
  - Registers: MASK=all 1, MODE=0, THRESH=0, COAL=0, PENDING=0, coal counter=0.
- Register map (word offsets):
  - 0x00 VERSION RO
  - 0x04 X_ID RO
  - 0x08 Y_ID RO
  - 0x0C RAW_STATUS RO, live condition per VC
  - 0x10 PENDING RW1C
  - 0x14 MASK RW [NUM_VC-1:0]
  - 0x18 MODE RW [1:0]
  - 0x1C THRESH RW [OCUP_W-1:0]
  - 0x20 COAL RW [COAL_W-1:0]
  - 0x40+4*i PKT_SIZE_VC(i) RO, for i<NUM_VC
- Unused register bits read 0; writes to them are ignored.
- Handshake: every cycle with csr_valid_i=1 is accepted. On the next cycle csr_rvalid_o=1 for exactly one cycle, carrying error/rdata.
- Error cases (csr_error_o=1):
  - unmapped or misaligned address (addr[1:0]!=0);
  - write to any RO register;
  - MODE write with value 3.
- On an error, the erroring write has no effect and the erroring read leaves csr_rdata_o unchanged.
- Condition per VC, by MODE:
  - 0: ~empty
  - 1: full
  - 2: ocup >= THRESH, unsigned compare
- PENDING[i] sets on a 0->1 edge of cond[i]; edge detection uses a registered copy of cond.
- PENDING W1C: bits written 1 clear, bits written 0 are held. If set and clear hit the same cycle, set wins.
- MODE write clears the cond history register, so a condition already true re-triggers PENDING on the next cycle.
- irq_vcs_o = PENDING & MASK, registered.
- Coalescing (any = |(PENDING & MASK)):
  - COAL=0: irq_trig_o = any, 1 cycle after PENDING updates.
  - COAL>0, while any: counter increments, saturating at COAL; irq_trig_o asserts when counter==COAL and stays high while any holds.
  - When any drops: counter clears to 0 and irq_trig_o deasserts the next cycle.
  - A COAL write restarts the counter at 0.
- Reads return the register value before any same-cycle update. Only one request exists per cycle, so read/write collisions are impossible.
- Reset mid-operation: a pending response is dropped and csr_rvalid_o goes 0 immediately (async).

Test Plan:
- Reset, then read 0x00/0x04/0x08 with X=2,Y=1 -> rvalid next cycle; rdata 0x0002_0000, 2, 1; error 0.
- Write 0x00 and read 0x3C -> error=1 both; rdata keeps the last good value; a following MASK read returns 0x7 (NUM_VC=3).
- MODE=0, COAL=0; drop empty_vc_i[1] -> PENDING=0b010, irq_vcs_o=0b010, irq_trig_o=1; write 0x10 data 0x2 while empty_vc_i[1] stays 0 -> PENDING=0, trig low, no re-set; toggle empty 1->0 -> set again.
- MODE=2, THRESH=5, ocup_vc_i[2] ramps 4->5 -> PENDING[2] sets on reaching 5; MASK=0b011 -> irq_vcs_o=0, trig 0 while PENDING[2] still reads 1.
- COAL=4, set PENDING[0] -> trig asserts exactly 4 cycles after the pending set cycle; clear via W1C -> trig low next cycle, counter 0.
- W1C of bit0 in the same cycle as a new edge on VC0 -> PENDING[0] remains 1; MODE write 3 -> error, MODE unchanged; assert arst_axi_n=0 mid-response -> all outputs 0 immediately.

Source files
------------

// File: rtl/ni_csr_irq_ctrl.sv
// ni_csr_irq_ctrl: network-interface CSR bank for the NI AXI slave.
// Single-beat CSR decode with a registered response one cycle after the request.
// Per-VC interrupt control: sticky W1C pending flags, mask, trigger-mode select
// with occupancy threshold, and an interrupt-coalescing timer.
module ni_csr_irq_ctrl #(
  parameter int          NUM_VC      = 3,
  parameter int          ROUTER_X_ID = 0,
  parameter int          ROUTER_Y_ID = 0,
  parameter int          ADDR_W      = 16,
  parameter int          OCUP_W      = 16,
  parameter int          PKT_W       = 8,
  parameter int          COAL_W      = 16,
  parameter logic [31:0] VERSION     = 32'h0002_0000
) (
  input  logic                     clk_axi,
  input  logic                     arst_axi_n,
  input  logic                     csr_valid_i,
  input  logic                     csr_wr_i,
  input  logic [ADDR_W-1:0]        csr_addr_i,
  input  logic [31:0]              csr_wdata_i,
  output logic                     csr_ready_o,
  output logic                     csr_rvalid_o,
  output logic [31:0]              csr_rdata_o,
  output logic                     csr_error_o,
  input  logic [NUM_VC-1:0]        empty_vc_i,
  input  logic [NUM_VC-1:0]        full_vc_i,
  input  logic [NUM_VC*OCUP_W-1:0] ocup_vc_i,
  input  logic [NUM_VC*PKT_W-1:0]  pkt_size_vc_i,
  output logic [NUM_VC-1:0]        irq_vcs_o,
  output logic                     irq_trig_o
);

  localparam logic [ADDR_W-1:0] A_VERSION = ADDR_W'(32'h00);
  localparam logic [ADDR_W-1:0] A_X_ID    = ADDR_W'(32'h04);
  localparam logic [ADDR_W-1:0] A_Y_ID    = ADDR_W'(32'h08);
  localparam logic [ADDR_W-1:0] A_RAW     = ADDR_W'(32'h0C);
  localparam logic [ADDR_W-1:0] A_PEND    = ADDR_W'(32'h10);
  localparam logic [ADDR_W-1:0] A_MASK    = ADDR_W'(32'h14);
  localparam logic [ADDR_W-1:0] A_MODE    = ADDR_W'(32'h18);
  localparam logic [ADDR_W-1:0] A_THRESH  = ADDR_W'(32'h1C);
  localparam logic [ADDR_W-1:0] A_COAL    = ADDR_W'(32'h20);

  logic [NUM_VC-1:0] mask_q, pending_q, cond, cond_p1, cond_edge, pend_clr;
  logic [1:0]        mode_q;
  logic [OCUP_W-1:0] thresh_q;
  logic [COAL_W-1:0] coal_q, coal_cnt_q, coal_cnt_nxt;
  logic [31:0]       rd_val;
  logic              hit, ro, req_err, wr_ok, any_irq;
  logic              we_pend, we_mask, we_mode, we_thresh, we_coal;

  assign csr_ready_o = 1'b1;

  // Live per-VC interrupt condition for the currently selected trigger mode
  always_comb begin
    cond = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      case (mode_q)
        2'd0:    cond[i] = ~empty_vc_i[i];
        2'd1:    cond[i] = full_vc_i[i];
        2'd2:    cond[i] = (ocup_vc_i[i*OCUP_W +: OCUP_W] >= thresh_q);
        default: cond[i] = 1'b0;
      endcase
    end
  end

  // Address decode: read value, mapped flag and read-only classification
  always_comb begin
    rd_val = '0;
    hit    = 1'b0;
    ro     = 1'b0;
    if (csr_addr_i[1:0] == 2'b00) begin
      if (csr_addr_i == A_VERSION) begin
        hit = 1'b1; ro = 1'b1; rd_val = VERSION;
      end else if (csr_addr_i == A_X_ID) begin
        hit = 1'b1; ro = 1'b1; rd_val = 32'(ROUTER_X_ID);
      end else if (csr_addr_i == A_Y_ID) begin
        hit = 1'b1; ro = 1'b1; rd_val = 32'(ROUTER_Y_ID);
      end else if (csr_addr_i == A_RAW) begin
        hit = 1'b1; ro = 1'b1; rd_val[NUM_VC-1:0] = cond;
      end else if (csr_addr_i == A_PEND) begin
        hit = 1'b1; rd_val[NUM_VC-1:0] = pending_q;
      end else if (csr_addr_i == A_MASK) begin
        hit = 1'b1; rd_val[NUM_VC-1:0] = mask_q;
      end else if (csr_addr_i == A_MODE) begin
        hit = 1'b1; rd_val[1:0] = mode_q;
      end else if (csr_addr_i == A_THRESH) begin
        hit = 1'b1; rd_val[OCUP_W-1:0] = thresh_q;
      end else if (csr_addr_i == A_COAL) begin
        hit = 1'b1; rd_val[COAL_W-1:0] = coal_q;
      end else begin
        for (int i = 0; i < NUM_VC; i++) begin
          if (csr_addr_i == ADDR_W'(64 + 4*i)) begin
            hit = 1'b1;
            ro  = 1'b1;
            rd_val[PKT_W-1:0] = pkt_size_vc_i[i*PKT_W +: PKT_W];
          end
        end
      end
    end
  end

  // An erroring request (unmapped, RO write, reserved MODE) must not touch state
  assign req_err   = ~hit | (csr_wr_i & (ro | ((csr_addr_i == A_MODE) & (csr_wdata_i[1:0] == 2'b11))));
  assign wr_ok     = csr_valid_i & csr_wr_i & ~req_err;
  assign we_pend   = wr_ok & (csr_addr_i == A_PEND);
  assign we_mask   = wr_ok & (csr_addr_i == A_MASK);
  assign we_mode   = wr_ok & (csr_addr_i == A_MODE);
  assign we_thresh = wr_ok & (csr_addr_i == A_THRESH);
  assign we_coal   = wr_ok & (csr_addr_i == A_COAL);

  assign pend_clr  = we_pend ? csr_wdata_i[NUM_VC-1:0] : '0;
  assign cond_edge = cond & ~cond_p1;
  assign any_irq   = |(pending_q & mask_q);
  // Counter saturates at COAL so it can sit there while the interrupt holds
  assign coal_cnt_nxt = (coal_cnt_q >= coal_q) ? coal_q : coal_cnt_q + COAL_W'(1);

  // Registered response; rdata only moves on a successful read
  always_ff @(posedge clk_axi or negedge arst_axi_n) begin
    if (!arst_axi_n) begin
      csr_rvalid_o <= 1'b0;
      csr_error_o  <= 1'b0;
      csr_rdata_o  <= '0;
    end else begin
      csr_rvalid_o <= csr_valid_i;
      csr_error_o  <= csr_valid_i & req_err;
      if (csr_valid_i && !csr_wr_i && !req_err)
        csr_rdata_o <= rd_val;
    end
  end

  // Configuration registers
  always_ff @(posedge clk_axi or negedge arst_axi_n) begin
    if (!arst_axi_n) begin
      mask_q   <= '1;
      mode_q   <= 2'd0;
      thresh_q <= '0;
      coal_q   <= '0;
    end else begin
      if (we_mask)   mask_q   <= csr_wdata_i[NUM_VC-1:0];
      if (we_mode)   mode_q   <= csr_wdata_i[1:0];
      if (we_thresh) thresh_q <= csr_wdata_i[OCUP_W-1:0];
      if (we_coal)   coal_q   <= csr_wdata_i[COAL_W-1:0];
    end
  end

  // Sticky pending flags (set beats W1C) and condition history; a MODE write
  // wipes the history so an already-true condition re-triggers
  always_ff @(posedge clk_axi or negedge arst_axi_n) begin
    if (!arst_axi_n) begin
      pending_q <= '0;
      cond_p1   <= '0;
    end else begin
      pending_q <= (pending_q & ~pend_clr) | cond_edge;
      cond_p1   <= we_mode ? '0 : cond;
    end
  end

  // Masked per-VC lines and the coalesced interrupt
  always_ff @(posedge clk_axi or negedge arst_axi_n) begin
    if (!arst_axi_n) begin
      irq_vcs_o  <= '0;
      irq_trig_o <= 1'b0;
      coal_cnt_q <= '0;
    end else begin
      irq_vcs_o <= pending_q & mask_q;
      if (we_coal) begin
        coal_cnt_q <= '0;
        irq_trig_o <= any_irq & (csr_wdata_i[COAL_W-1:0] == '0);
      end else if (any_irq) begin
        coal_cnt_q <= coal_cnt_nxt;
        irq_trig_o <= (coal_cnt_nxt == coal_q);
      end else begin
        coal_cnt_q <= '0;
        irq_trig_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ni_csr_irq_ctrl.sv
// tb_ni_csr_irq_ctrl: directed and randomized checks of ni_csr_irq_ctrl
// (NUM_VC=3, X=2, Y=1) against a register-level reference model.
module tb_ni_csr_irq_ctrl;
  localparam int NVC = 3;

  logic              clk_axi = 1'b0;
  logic              arst_axi_n;
  logic              csr_valid_i, csr_wr_i;
  logic [15:0]       csr_addr_i;
  logic [31:0]       csr_wdata_i;
  logic              csr_ready_o, csr_rvalid_o, csr_error_o;
  logic [31:0]       csr_rdata_o;
  logic [NVC-1:0]    empty_vc_i, full_vc_i, irq_vcs_o;
  logic [NVC*16-1:0] ocup_vc_i;
  logic [NVC*8-1:0]  pkt_size_vc_i;
  logic              irq_trig_o;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [2:0]  m_mask, m_pend, m_prev;
  logic [1:0]  m_mode;
  logic [15:0] m_thresh, m_coal;
  int          m_run;   // consecutive cycles with a masked pending flag
  logic        e_rvalid, e_err, e_trig;
  logic [31:0] e_rdata;
  logic [2:0]  e_irq;

  logic [15:0] addrs [16] = '{16'h00, 16'h04, 16'h08, 16'h0C, 16'h10, 16'h14, 16'h18, 16'h1C,
                              16'h20, 16'h40, 16'h44, 16'h48, 16'h4C, 16'h3C, 16'h12, 16'h24};

  ni_csr_irq_ctrl #(
    .NUM_VC(NVC), .ROUTER_X_ID(2), .ROUTER_Y_ID(1), .ADDR_W(16),
    .OCUP_W(16), .PKT_W(8), .COAL_W(16), .VERSION(32'h0002_0000)
  ) dut (
    .clk_axi(clk_axi), .arst_axi_n(arst_axi_n),
    .csr_valid_i(csr_valid_i), .csr_wr_i(csr_wr_i), .csr_addr_i(csr_addr_i),
    .csr_wdata_i(csr_wdata_i), .csr_ready_o(csr_ready_o), .csr_rvalid_o(csr_rvalid_o),
    .csr_rdata_o(csr_rdata_o), .csr_error_o(csr_error_o),
    .empty_vc_i(empty_vc_i), .full_vc_i(full_vc_i), .ocup_vc_i(ocup_vc_i),
    .pkt_size_vc_i(pkt_size_vc_i), .irq_vcs_o(irq_vcs_o), .irq_trig_o(irq_trig_o)
  );

  always #5 clk_axi = ~clk_axi;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] m_cond();
    logic [2:0] c;
    c = 3'b0;
    for (int i = 0; i < NVC; i++) begin
      if (m_mode == 2'd0)      c[i] = !empty_vc_i[i];
      else if (m_mode == 2'd1) c[i] = full_vc_i[i];
      else                     c[i] = (ocup_vc_i[i*16 +: 16] >= m_thresh);
    end
    return c;
  endfunction

  function automatic bit m_legal(input logic [15:0] a, input bit wr, input logic [31:0] wd);
    case (a)
      16'h00, 16'h04, 16'h08, 16'h0C, 16'h40, 16'h44, 16'h48: return !wr;
      16'h10, 16'h14, 16'h1C, 16'h20: return 1'b1;
      16'h18: return !(wr && wd[1:0] == 2'b11);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [15:0] a);
    logic [31:0] r;
    r = 32'h0;
    case (a)
      16'h00: r = 32'h0002_0000;
      16'h04: r = 32'd2;
      16'h08: r = 32'd1;
      16'h0C: r = {29'b0, m_cond()};
      16'h10: r = {29'b0, m_pend};
      16'h14: r = {29'b0, m_mask};
      16'h18: r = {30'b0, m_mode};
      16'h1C: r = {16'b0, m_thresh};
      16'h20: r = {16'b0, m_coal};
      16'h40: r = {24'b0, pkt_size_vc_i[7:0]};
      16'h44: r = {24'b0, pkt_size_vc_i[15:8]};
      16'h48: r = {24'b0, pkt_size_vc_i[23:16]};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_mask = 3'b111; m_mode = 2'd0; m_thresh = 16'h0; m_coal = 16'h0;
    m_pend = 3'b0; m_prev = 3'b0; m_run = 0;
    e_rvalid = 1'b0; e_err = 1'b0; e_trig = 1'b0; e_rdata = 32'h0; e_irq = 3'b0;
  endtask

  task automatic check_all();
    chk("rvalid", 32'(csr_rvalid_o), 32'(e_rvalid));
    chk("error", 32'(csr_error_o), 32'(e_err));
    chk("rdata", csr_rdata_o, e_rdata);
    chk("irq_vcs", 32'(irq_vcs_o), 32'(e_irq));
    chk("irq_trig", 32'(irq_trig_o), 32'(e_trig));
  endtask

  // One clock: drive a request, predict the outcome, clock, compare
  task automatic step(input bit v, input bit wr, input logic [15:0] a, input logic [31:0] wd);
    logic [2:0]  c, clr, npend, nprev;
    logic [31:0] rv;
    bit          ok, w, anyv;
    csr_valid_i = v; csr_wr_i = wr; csr_addr_i = a; csr_wdata_i = wd;
    c     = m_cond();
    ok    = v && m_legal(a, wr, wd);
    w     = ok && wr;
    rv    = m_read(a);
    clr   = (w && a == 16'h10) ? wd[2:0] : 3'b0;
    npend = (m_pend & ~clr) | (c & ~m_prev);
    nprev = (w && a == 16'h18) ? 3'b0 : c;
    e_irq = m_pend & m_mask;
    anyv  = (e_irq != 3'b0);
    if (w && a == 16'h20) begin
      m_run = 0; e_trig = anyv && (wd[15:0] == 16'h0);
    end else if (anyv) begin
      m_run++; e_trig = (m_run >= int'(m_coal));
    end else begin
      m_run = 0; e_trig = 1'b0;
    end
    if (w) begin
      case (a)
        16'h14: m_mask   = wd[2:0];
        16'h18: m_mode   = wd[1:0];
        16'h1C: m_thresh = wd[15:0];
        16'h20: m_coal   = wd[15:0];
        default: ;
      endcase
    end
    e_rvalid = v;
    e_err    = v && !ok;
    if (ok && !wr) e_rdata = rv;
    m_pend = npend;
    m_prev = nprev;
    @(posedge clk_axi);
    #1;
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 16'h0, 32'h0);
  endtask

  task automatic set_ocup(input int i, input logic [15:0] v);
    ocup_vc_i[i*16 +: 16] = v;
  endtask

  initial begin
    logic [15:0] a;
    logic [31:0] wd;
    bit          wr;
    arst_axi_n = 1'b1;
    csr_valid_i = 1'b0; csr_wr_i = 1'b0; csr_addr_i = 16'h0; csr_wdata_i = 32'h0;
    empty_vc_i = 3'b111; full_vc_i = 3'b000; ocup_vc_i = '0;
    pkt_size_vc_i = {8'd30, 8'd20, 8'd10};
    #2 arst_axi_n = 1'b0;
    #1;
    model_reset();
    chk("rst_rvalid", 32'(csr_rvalid_o), 32'h0);
    chk("rst_rdata", csr_rdata_o, 32'h0);
    chk("rst_error", 32'(csr_error_o), 32'h0);
    chk("rst_irq_vcs", 32'(irq_vcs_o), 32'h0);
    chk("rst_irq_trig", 32'(irq_trig_o), 32'h0);
    chk("ready", 32'(csr_ready_o), 32'h1);
    @(posedge clk_axi); @(posedge clk_axi); #1;
    arst_axi_n = 1'b1;

    // Identification registers
    step(1, 0, 16'h00, 0); chk("version", csr_rdata_o, 32'h0002_0000);
    step(1, 0, 16'h04, 0); chk("x_id", csr_rdata_o, 32'd2);
    step(1, 0, 16'h08, 0); chk("y_id", csr_rdata_o, 32'd1);

    // RO write and unmapped read error; rdata holds
    step(1, 1, 16'h00, 32'h5); chk("ro_wr_err", 32'(csr_error_o), 32'h1);
    step(1, 0, 16'h3C, 0);     chk("unmapped_err", 32'(csr_error_o), 32'h1);
    chk("rdata_held", csr_rdata_o, 32'd1);
    step(1, 0, 16'h14, 0);     chk("mask_reset", csr_rdata_o, 32'h7);
    step(1, 0, 16'h42, 0);     chk("misaligned_err", 32'(csr_error_o), 32'h1);
    step(1, 0, 16'h44, 0);     chk("pkt_vc1", csr_rdata_o, 32'd20);

    // Mode 0: empty-drop sets pending; W1C clears without re-set
    step(1, 1, 16'h18, 0);
    step(1, 1, 16'h20, 0);
    empty_vc_i = 3'b101;
    idle(); idle();
    chk("m0_irq_vcs", 32'(irq_vcs_o), 32'h2);
    chk("m0_trig", 32'(irq_trig_o), 32'h1);
    step(1, 0, 16'h10, 0); chk("m0_pend", csr_rdata_o, 32'h2);
    step(1, 1, 16'h10, 32'h2);
    idle(); idle();
    chk("w1c_irq_vcs", 32'(irq_vcs_o), 32'h0);
    chk("w1c_trig", 32'(irq_trig_o), 32'h0);
    step(1, 0, 16'h10, 0); chk("w1c_pend", csr_rdata_o, 32'h0);
    empty_vc_i = 3'b111; idle();
    empty_vc_i = 3'b101; idle();
    step(1, 0, 16'h10, 0); chk("reset_again", csr_rdata_o, 32'h2);

    // Mode 2: occupancy threshold, then mask VC2 out
    step(1, 1, 16'h1C, 32'd5);
    step(1, 1, 16'h18, 32'd2);
    step(1, 1, 16'h10, 32'h7);
    set_ocup(2, 16'd4); idle(); idle();
    step(1, 0, 16'h10, 0); chk("thr_below", csr_rdata_o, 32'h0);
    set_ocup(2, 16'd5); idle(); idle();
    step(1, 0, 16'h10, 0); chk("thr_reach", csr_rdata_o, 32'h4);
    step(1, 1, 16'h14, 32'h3); idle(); idle();
    chk("masked_irq_vcs", 32'(irq_vcs_o), 32'h0);
    chk("masked_trig", 32'(irq_trig_o), 32'h0);
    step(1, 0, 16'h10, 0); chk("masked_pend", csr_rdata_o, 32'h4);

    // Coalescing with COAL=4
    set_ocup(2, 16'd0);
    step(1, 1, 16'h10, 32'h7);
    empty_vc_i = 3'b111;
    step(1, 1, 16'h18, 0);
    step(1, 1, 16'h14, 32'h7);
    step(1, 1, 16'h20, 32'd4);
    for (int r = 0; r < 2; r++) begin
      empty_vc_i[0] = 1'b1; idle();
      empty_vc_i[0] = 1'b0; idle();
      for (int k = 1; k <= 4; k++) begin
        idle();
        chk("coal_delay", 32'(irq_trig_o), 32'(k == 4));
      end
      if (r == 0) begin
        step(1, 1, 16'h10, 32'h1);
        idle();
        chk("coal_clear_trig", 32'(irq_trig_o), 32'h0);
      end
    end

    // Set wins over same-cycle W1C; reserved MODE rejected
    step(1, 1, 16'h20, 0);
    empty_vc_i[0] = 1'b1; idle();
    empty_vc_i[0] = 1'b0;
    step(1, 1, 16'h10, 32'h1);
    step(1, 0, 16'h10, 0); chk("set_wins", csr_rdata_o, 32'h1);
    step(1, 1, 16'h18, 32'h3); chk("mode3_err", 32'(csr_error_o), 32'h1);
    step(1, 0, 16'h18, 0);     chk("mode_kept", csr_rdata_o, 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      if (n % 4 == 0) begin
        empty_vc_i = 3'($urandom);
        full_vc_i  = 3'($urandom);
        for (int i = 0; i < NVC; i++) set_ocup(i, 16'($urandom_range(0, 7)));
      end
      a  = addrs[$urandom_range(0, 15)];
      wr = 1'($urandom);
      wd = $urandom;
      if (a == 16'h20) wd = 32'($urandom_range(0, 5));
      if (a == 16'h1C) wd = 32'($urandom_range(0, 7));
      if (a == 16'h18) wd = 32'($urandom_range(0, 3));
      step(1'($urandom), wr, a, wd);
    end

    // Asynchronous reset while a response is on the bus
    step(1, 0, 16'h00, 0);
    chk("pre_rst_rvalid", 32'(csr_rvalid_o), 32'h1);
    #2 arst_axi_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", 32'(csr_rvalid_o), 32'h0);
    chk("mid_rst_rdata", csr_rdata_o, 32'h0);
    chk("mid_rst_error", 32'(csr_error_o), 32'h0);
    chk("mid_rst_irq_vcs", 32'(irq_vcs_o), 32'h0);
    chk("mid_rst_trig", 32'(irq_trig_o), 32'h0);
    model_reset();
    csr_valid_i = 1'b0;
    @(posedge clk_axi); #1;
    arst_axi_n = 1'b1;
    step(1, 0, 16'h14, 0); chk("post_rst_mask", csr_rdata_o, 32'h7);
    step(1, 0, 16'h18, 0); chk("post_rst_mode", csr_rdata_o, 32'h0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
